// File: rtl/hex_scan.sv
// hex_scan: multiplexed hex seven-segment scanner with frame-synchronous display update.
//   Optional feature: define HEX_SCAN_BLINK_EN to add blink_mask and BLINK_FRAMES.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   data_in    : nibble k (bits 4k+3..4k) is the value for digit k
//   load       : capture request for data_in
//   blank      : bit k blanks digit k (used live)
//   blink_mask : (HEX_SCAN_BLINK_EN only) digits that blink
//   seg        : registered segments g..a, bit 0 = a
//   dig_sel    : registered one-hot digit enable
//   frame_done : one-cycle pulse the cycle after each frame boundary
//   pending    : shadow holds data not yet displayed
module hex_scan #(
    parameter int DIGITS = 4,
    parameter int DIV = 50000,
    parameter int ACTIVE_LOW = 1
`ifdef HEX_SCAN_BLINK_EN
    , parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blank,
`ifdef HEX_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done,
    output logic                  pending
);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
    localparam logic [111:0] SEG_LUT = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_q, disp_d, shad_q, shad_d;
    logic                pend_q, pend_d, fd_q, fd_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                wrap, boundary, off;
    logic [3:0]          nib;
`ifdef HEX_SCAN_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BHALF = BW'(BLINK_FRAMES / 2);
    logic [BW-1:0] blk_q, blk_d;
`endif
    always_comb begin
        wrap = presc_q == PMAX;
        boundary = wrap && idx_q == IMAX;
        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d = wrap ? (idx_q == IMAX ? '0 : idx_q + 1'b1) : idx_q;
        shad_d = load ? data_in : shad_q;
        // A load landing on the boundary goes straight to the display, so nothing is left pending.
        pend_d = boundary ? 1'b0 : (load | pend_q);
        disp_d = boundary && load ? data_in : boundary && pend_q ? shad_q : disp_q;
        fd_d = boundary;
        nib = disp_q[idx_q*4 +: 4];
        off = blank[idx_q];
`ifdef HEX_SCAN_BLINK_EN
        blk_d = boundary ? (blk_q == BMAX ? '0 : blk_q + 1'b1) : blk_q;
        off = off | (blink_mask[idx_q] && blk_q >= BHALF);
`endif
        seg_d = off ? 7'h00 : SEG_LUT[nib*7 +: 7];
        sel_d = DIGITS'(1) << idx_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            shad_q  <= '0;
            pend_q  <= 1'b0;
            fd_q    <= 1'b0;
            seg_q   <= '0;
            sel_q   <= '0;
`ifdef HEX_SCAN_BLINK_EN
            blk_q   <= '0;
`endif
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            shad_q  <= shad_d;
            pend_q  <= pend_d;
            fd_q    <= fd_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
`ifdef HEX_SCAN_BLINK_EN
            blk_q   <= blk_d;
`endif
        end
    end
    // Registers hold logical levels; polarity is applied only at the pins.
    assign seg = ACTIVE_LOW != 0 ? ~seg_q : seg_q;
    assign dig_sel = ACTIVE_LOW != 0 ? ~sel_q : sel_q;
    assign frame_done = fd_q;
    assign pending = pend_q;
endmodule

// File: tb/tb_hex_scan.sv
// tb_hex_scan: directed self-checking bench for hex_scan (DIGITS=4, DIV=4, ACTIVE_LOW=0).
module tb_hex_scan;
    typedef struct {
        logic [15:0]      data;
        logic [3:0]       blank;
        logic [3:0][6:0]  exp;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0, load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0] blank = '0;
`ifdef HEX_SCAN_BLINK_EN
    logic [3:0] blink_mask = '0;
`endif
    logic [6:0] seg;
    logic [3:0] dig_sel;
    logic frame_done, pending;
    int tests = 0, fails = 0;
    vec_t vecs[4];
    always #5 clk = ~clk;
    hex_scan #(
        .DIGITS(4), .DIV(4), .ACTIVE_LOW(0)
`ifdef HEX_SCAN_BLINK_EN
        , .BLINK_FRAMES(4)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .blank(blank),
`ifdef HEX_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg(seg), .dig_sel(dig_sel), .frame_done(frame_done), .pending(pending)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic wait_fd;
        int n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("wait_fd", frame_done, 1);
    endtask
    // Starts on a frame_done sample, runs one full frame and records the segment value
    // seen for each selected digit. load_at = number of ticks before driving load (-1: none).
    task automatic capture(input string name, input logic [3:0][6:0] exp,
                           input int load_at, input logic [15:0] ld);
        logic [7:0] got[4];
        int mid = 0;
        for (int k = 0; k < 4; k++) got[k] = 8'h80;
        for (int t = 1; t <= 16; t++) begin
            if (t - 1 == load_at) begin
                load = 1'b1;
                data_in = ld;
            end
            tick;
            load = 1'b0;
            if (t - 1 == load_at) chk({name, "_pend_after_load"}, pending, load_at == 15 ? 0 : 1);
            for (int k = 0; k < 4; k++) if (dig_sel == 4'(1 << k)) got[k] = {1'b0, seg};
            if (t < 16 && frame_done) mid++;
        end
        chk({name, "_fd_end"}, frame_done, 1);
        chk({name, "_fd_mid"}, mid, 0);
        chk({name, "_pend_end"}, pending, 0);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_d%0d", name, k), got[k], {1'b0, exp[k]});
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        vecs[0] = '{16'h5678, 4'b0000, {7'h6D, 7'h7D, 7'h07, 7'h7F}};
        vecs[1] = '{16'h90EF, 4'b0000, {7'h6F, 7'h3F, 7'h79, 7'h71}};
        vecs[2] = '{16'h1234, 4'b1001, {7'h00, 7'h5B, 7'h4F, 7'h00}};
        vecs[3] = '{16'hCAFE, 4'b0010, {7'h39, 7'h77, 7'h00, 7'h79}};
        tick;
        tick;
        chk("rst_seg", seg, 0);
        chk("rst_sel", dig_sel, 0);
        chk("rst_pend", pending, 0);
        chk("rst_fd", frame_done, 0);
        rst_n = 1'b1;
        tick;
        chk("first_seg", seg, 7'h3F);
        chk("first_sel", dig_sel, 4'b0001);
        load = 1'b1;
        data_in = 16'h1234;
        tick;
        load = 1'b0;
        chk("r029_pend_set", pending, 1);
        wait_fd;
        chk("r029_pend_clr", pending, 0);
        capture("r029", {7'h06, 7'h5B, 7'h4F, 7'h66}, -1, 16'h0);
        capture("r030_old", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4, 16'hABCD);
        capture("r030_new", {7'h77, 7'h7C, 7'h39, 7'h5E}, -1, 16'h0);
        capture("r032_old", {7'h77, 7'h7C, 7'h39, 7'h5E}, 15, 16'h00FF);
        capture("r032_new", {7'h3F, 7'h3F, 7'h71, 7'h71}, -1, 16'h0);
        blank = 4'b0100;
        capture("r031", {7'h3F, 7'h00, 7'h71, 7'h71}, -1, 16'h0);
        blank = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            load = 1'b1;
            data_in = vecs[v].data;
            tick;
            load = 1'b0;
            wait_fd;
            blank = vecs[v].blank;
            capture($sformatf("vec%0d", v), vecs[v].exp, -1, 16'h0);
            blank = 4'b0000;
        end
        load = 1'b1;
        data_in = 16'h5555;
        tick;
        load = 1'b0;
        chk("r033_pend_set", pending, 1);
        for (int i = 0; i < 7; i++) tick;
        rst_n = 1'b0;
        tick;
        chk("r033_seg", seg, 0);
        chk("r033_sel", dig_sel, 0);
        chk("r033_pend", pending, 0);
        chk("r033_fd", frame_done, 0);
        rst_n = 1'b1;
        tick;
        chk("r033_seg0", seg, 7'h3F);
        chk("r033_sel0", dig_sel, 4'b0001);
        wait_fd;
        capture("r033_frame", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, -1, 16'h0);
`ifdef HEX_SCAN_BLINK_EN
        blink_mask = 4'b0001;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        for (int f = 1; f <= 4; f++) begin
            logic [3:0][6:0] e;
            e = {7'h3F, 7'h3F, 7'h3F, (f % 4 >= 2) ? 7'h00 : 7'h3F};
            wait_fd;
            capture($sformatf("blink_f%0d", f), e, -1, 16'h0);
        end
        blink_mask = 4'b0000;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
